// File: rtl/volume_qc_pkg.sv
// Shared constants and helpers for the volume / Q-control mixer on the PAC-PLL
// excitation path.
package volume_qc_pkg;

  localparam int ADC_WIDTH_DEF       = 14;
  localparam int SIGNAL_M_WIDTH_DEF  = 16;
  localparam int AXIS_DATA_WIDTH_DEF = 16;
  localparam int AXIS_TDATA_WIDTH_DEF = 32;
  localparam int VOL_WIDTH_DEF       = 16;
  localparam int VOL_Q_DEF           = 14;
  localparam int DELAY_LEN2_DEF      = 13;
  localparam int PIPE_LAT            = 3;

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic is_clipped(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // A zero delay would read the slot being written; the line depth caps the top.
  function automatic logic [15:0] clamp_delay(input logic [15:0] d, input int len2);
    logic [16:0] dmax;
    dmax = 17'((1 << len2) - 1);
    if (d == 16'd0) return 16'd1;
    else if ({1'b0, d} > dmax) return dmax[15:0];
    return d;
  endfunction

endpackage

// File: rtl/volume_qc_mixer_delay.sv
// Fill-tracked circular delay line for the Q-control signal; dout is valid one
// cycle after a strobe and reads zero until the line holds D samples.
module qc_delay_line
  import volume_qc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DELAY_LEN2 = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strobe,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [15:0]       delay,
  output logic signed [DATA_W-1:0] dout
);
  localparam int DEPTH = 1 << DELAY_LEN2;

  logic signed [DATA_W-1:0]     mem [DEPTH];
  logic signed [DATA_W-1:0]     rd_q;
  logic        [DELAY_LEN2-1:0] wp, fill, dly, ra;
  logic        [15:0]           dly_full;
  logic                         hit_q;

  assign dly_full = clamp_delay(delay, DELAY_LEN2);
  assign dly      = DELAY_LEN2'(dly_full);
  assign ra       = wp - dly;

  always_ff @(posedge clk) begin
    if (strobe && enable) begin
      mem[wp] <= din;
      rd_q    <= mem[ra];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      fill  <= '0;
      hit_q <= 1'b0;
    end else begin
      if (!enable) fill <= '0;
      if (strobe) hit_q <= enable && (fill >= dly);
      if (strobe && enable) begin
        wp <= wp + DELAY_LEN2'(1);
        if (fill != '1) fill <= fill + DELAY_LEN2'(1);
      end
    end
  end

  assign dout = hit_q ? rd_q : '0;

endmodule

// File: rtl/volume_qc_mixer.sv
// Slew-limited volume scaling of the excitation sample plus an optional delayed,
// gain-scaled Q-control term, rounded and saturated back to ADC width.
module volume_qc_mixer
  import volume_qc_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_WIDTH_DEF,
  parameter int SIGNAL_M_WIDTH   = SIGNAL_M_WIDTH_DEF,
  parameter int AXIS_DATA_WIDTH  = AXIS_DATA_WIDTH_DEF,
  parameter int AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
  parameter int VOL_WIDTH        = VOL_WIDTH_DEF,
  parameter int VOL_Q            = VOL_Q_DEF,
  parameter int DELAY_LEN2       = DELAY_LEN2_DEF
) (
  input  logic                             a_clk,
  input  logic                             a_rst,
  input  logic        [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                             S_AXIS_tvalid,
  input  logic signed [VOL_WIDTH-1:0]      SV_AXIS_tdata,
  input  logic                             SV_AXIS_tvalid,
  input  logic signed [SIGNAL_M_WIDTH-1:0] S_AXIS_SIGNAL_M_tdata,
  input  logic                             S_AXIS_SIGNAL_M_tvalid,
  input  logic                             QC_enable,
  input  logic signed [VOL_WIDTH-1:0]      QC_gain,
  input  logic        [15:0]               QC_delay,
  input  logic        [VOL_WIDTH-1:0]      ramp_step,
  output logic        [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                             M_AXIS_tvalid,
  output logic                             sat_flag,
  output logic                             ramp_busy
);
  localparam int PV_W  = VOL_WIDTH + ADC_WIDTH;
  localparam int PQ_W  = VOL_WIDTH + SIGNAL_M_WIDTH;
  localparam int QSH   = SIGNAL_M_WIDTH - ADC_WIDTH;
  localparam int ACC_W = ((PV_W > PQ_W) ? PV_W : PQ_W) + 2;

  function automatic logic signed [ACC_W-1:0] round_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] half;
    half = ACC_W'(1) << (VOL_Q - 1);
    return (a + half) >>> VOL_Q;
  endfunction

  logic                        strobe;
  logic signed [VOL_WIDTH-1:0] v_cur, v_next, target;
  logic signed [VOL_WIDTH:0]   v_ext, diff, step_s, v_moved;
  logic        [VOL_WIDTH:0]   diff_abs;
  logic                        unused_ok;

  assign strobe    = S_AXIS_tvalid & SV_AXIS_tvalid;
  assign ramp_busy = (v_cur != SV_AXIS_tdata);
  assign unused_ok = &{1'b0, S_AXIS_SIGNAL_M_tvalid};

  always_comb begin
    target   = SV_AXIS_tdata;
    v_ext    = {v_cur[VOL_WIDTH-1], v_cur};
    diff     = {target[VOL_WIDTH-1], target} - v_ext;
    diff_abs = diff[VOL_WIDTH] ? unsigned'(-diff) : unsigned'(diff);
    step_s   = signed'({1'b0, ramp_step});
    v_moved  = diff[VOL_WIDTH] ? (v_ext - step_s) : (v_ext + step_s);
    if ((ramp_step == '0) || (diff_abs <= {1'b0, ramp_step})) v_next = target;
    else v_next = v_moved[VOL_WIDTH-1:0];
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) v_cur <= '0;
    else if (strobe) v_cur <= v_next;
  end

  // S1: capture sample, pre-update volume, gain; delay line read in parallel
  logic signed [ADC_WIDTH-1:0]      x_p0;
  logic signed [VOL_WIDTH-1:0]      v_p0, g_p0;
  logic signed [SIGNAL_M_WIDTH-1:0] d_p0;
  logic        [AXIS_DATA_WIDTH-1:0] lo_p0;
  logic                             vld_p0;

  qc_delay_line #(
    .DATA_W     (SIGNAL_M_WIDTH),
    .DELAY_LEN2 (DELAY_LEN2)
  ) u_delay (
    .clk    (a_clk),
    .rst    (a_rst),
    .strobe (strobe),
    .enable (QC_enable),
    .din    (S_AXIS_SIGNAL_M_tdata),
    .delay  (QC_delay),
    .dout   (d_p0)
  );

  always_ff @(posedge a_clk) begin
    if (strobe) begin
      x_p0  <= ADC_WIDTH'(S_AXIS_tdata >> AXIS_DATA_WIDTH);
      v_p0  <= v_cur;
      g_p0  <= QC_gain;
      lo_p0 <= S_AXIS_tdata[AXIS_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) vld_p0 <= 1'b0;
    else vld_p0 <= strobe;
  end

  // S2: products
  logic signed [PV_W-1:0]           pv_p1;
  logic signed [PQ_W-1:0]           pq_p1;
  logic        [AXIS_DATA_WIDTH-1:0] lo_p1;
  logic                             vld_p1;

  always_ff @(posedge a_clk) begin
    if (vld_p0) begin
      pv_p1 <= PV_W'(v_p0) * PV_W'(x_p0);
      pq_p1 <= PQ_W'(g_p0) * PQ_W'(d_p0);
      lo_p1 <= lo_p0;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) vld_p1 <= 1'b0;
    else vld_p1 <= vld_p0;
  end

  // S3: sum, round, saturate into the output word
  logic signed [PQ_W-1:0]      pq_sh;
  logic signed [ACC_W-1:0]     acc, rnd;
  logic signed [63:0]          rnd64, y64;
  logic signed [ADC_WIDTH-1:0] y;
  logic                        clip;

  always_comb begin
    pq_sh = pq_p1 >>> QSH;
    acc   = ACC_W'(pv_p1) + ACC_W'(pq_sh);
    rnd   = round_q(acc);
    rnd64 = 64'(rnd);
    y64   = sat_signed(rnd64, ADC_WIDTH);
    clip  = is_clipped(rnd64, ADC_WIDTH);
    y     = ADC_WIDTH'(y64);
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata  <= '0;
      sat_flag      <= 1'b0;
    end else begin
      M_AXIS_tvalid <= vld_p1;
      if (vld_p1) begin
        M_AXIS_tdata <= {{(AXIS_DATA_WIDTH - ADC_WIDTH){y[ADC_WIDTH-1]}}, y, lo_p1};
        sat_flag     <= clip;
      end
    end
  end

endmodule

// File: tb/tb_volume_qc_mixer.sv
// Directed and randomized bench for volume_qc_mixer with an arithmetic reference model.
module tb_volume_qc_mixer;
  localparam int DL2  = 4;
  localparam int DMAX = (1 << DL2) - 1;

  logic               a_clk = 1'b0;
  logic               a_rst;
  logic        [31:0] s_tdata;
  logic               s_tvalid;
  logic signed [15:0] sv_tdata;
  logic               sv_tvalid;
  logic signed [15:0] sig;
  logic               sig_vld;
  logic               qc_en;
  logic signed [15:0] qc_gain;
  logic        [15:0] qc_delay;
  logic        [15:0] ramp_step;
  logic        [31:0] m_tdata;
  logic               m_tvalid, sat_flag, ramp_busy;

  always #5 a_clk = ~a_clk;

  volume_qc_mixer #(.DELAY_LEN2(DL2)) dut (
    .a_clk                  (a_clk),
    .a_rst                  (a_rst),
    .S_AXIS_tdata           (s_tdata),
    .S_AXIS_tvalid          (s_tvalid),
    .SV_AXIS_tdata          (sv_tdata),
    .SV_AXIS_tvalid         (sv_tvalid),
    .S_AXIS_SIGNAL_M_tdata  (sig),
    .S_AXIS_SIGNAL_M_tvalid (sig_vld),
    .QC_enable              (qc_en),
    .QC_gain                (qc_gain),
    .QC_delay               (qc_delay),
    .ramp_step              (ramp_step),
    .M_AXIS_tdata           (m_tdata),
    .M_AXIS_tvalid          (m_tvalid),
    .sat_flag               (sat_flag),
    .ramp_busy              (ramp_busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        sat;
  } exp_t;

  exp_t               expq[$];
  int                 hist[$];
  int                 v_cur_m;
  int                 cyc;
  logic        [31:0] last_data;
  logic               last_sat;
  logic signed [13:0] x_in;
  logic        [15:0] lo_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: one accepted sample, computed straight from the arithmetic rules.
  task automatic model_strobe();
    longint acc, y;
    int     d, dly, diff;
    exp_t   e;
    dly = (qc_delay == 16'd0) ? 1 : ((int'(qc_delay) > DMAX) ? DMAX : int'(qc_delay));
    if (qc_en) begin
      d = (hist.size() >= dly) ? hist[hist.size() - dly] : 0;
      hist.push_back(int'(sig));
      if (hist.size() > DMAX + 1) void'(hist.pop_front());
    end else d = 0;
    acc = longint'(v_cur_m) * longint'(x_in) + ((longint'(qc_gain) * longint'(d)) >>> 2);
    y = (acc + 64'sd8192) >>> 14;
    e.sat = (y > 8191) || (y < -8192);
    if (y > 8191) y = 8191;
    if (y < -8192) y = -8192;
    e.data = {y[15:0], lo_in};
    e.due = cyc + 3;
    expq.push_back(e);
    diff = int'(sv_tdata) - v_cur_m;
    if (ramp_step == 16'd0 || ((diff < 0) ? -diff : diff) <= int'(ramp_step)) v_cur_m = int'(sv_tdata);
    else v_cur_m = v_cur_m + ((diff > 0) ? int'(ramp_step) : -int'(ramp_step));
  endtask

  task automatic tick();
    exp_t e;
    s_tdata = {2'($urandom), x_in, lo_in};
    if (!qc_en) hist.delete();
    if (s_tvalid && sv_tvalid) model_strobe();
    @(posedge a_clk);
    #1;
    cyc++;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      last_data = e.data;
      last_sat  = e.sat;
      chk("tvalid", 32'(m_tvalid), 32'd1);
      chk("tdata", m_tdata, e.data);
      chk("sat_flag", 32'(sat_flag), 32'(e.sat));
    end else begin
      chk("tvalid_idle", 32'(m_tvalid), 32'd0);
      chk("tdata_hold", m_tdata, last_data);
      chk("sat_hold", 32'(sat_flag), 32'(last_sat));
    end
    chk("ramp_busy", 32'(ramp_busy), 32'(v_cur_m != int'(sv_tdata)));
  endtask

  task automatic strobe(input logic signed [13:0] x, input logic [15:0] lo,
                        input logic signed [15:0] s);
    x_in = x; lo_in = lo; sig = s;
    s_tvalid = 1'b1; sv_tvalid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b0; sv_tvalid = 1'($urandom);
      x_in = 14'($urandom); sig = 16'($urandom);
      tick();
    end
  endtask

  task automatic do_reset();
    a_rst = 1'b1; s_tvalid = 1'b0; sv_tvalid = 1'b0; sv_tdata = '0;
    @(posedge a_clk);
    #1;
    cyc++;
    expq.delete(); hist.delete();
    v_cur_m = 0; last_data = '0; last_sat = 1'b0;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_busy", 32'(ramp_busy), 32'd0);
    a_rst = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; s_tvalid = 1'b0; sv_tvalid = 1'b0; sv_tdata = '0;
    sig = '0; sig_vld = 1'b0; qc_en = 1'b0; qc_gain = '0; qc_delay = '0;
    ramp_step = '0; x_in = '0; lo_in = '0; s_tdata = '0; cyc = 0;
    do_reset();
    idle(2);

    sv_tdata = 16384;
    strobe(0, 16'h0000, 0);
    strobe(1000, 16'hA5A5, 0);
    idle(3);
    chk("scale_unity", m_tdata, 32'h03E8_A5A5);

    sv_tdata = 8192;
    strobe(0, 16'h1234, 0);
    strobe(-1001, 16'h1234, 0);
    idle(3);
    chk("scale_half", 32'(m_tdata[31:16]), 32'h0000_FE0C);

    sv_tdata = 32767;
    strobe(0, 16'h0, 0);
    strobe(8191, 16'h0, 0);
    idle(3);
    chk("sat_pos_y", 32'(m_tdata[31:16]), 32'h0000_1FFF);
    chk("sat_pos_flag", 32'(sat_flag), 32'd1);
    strobe(-8192, 16'h0, 0);
    idle(3);
    chk("sat_neg_y", 32'(m_tdata[31:16]), 32'h0000_E000);
    chk("sat_neg_flag", 32'(sat_flag), 32'd1);

    sv_tdata = 0;
    strobe(0, 16'h0, 0);
    qc_en = 1'b1; qc_gain = 16384; qc_delay = 5;
    strobe(14'($urandom), 16'h0, 4000);
    for (int k = 1; k <= 5; k++) strobe(14'($urandom), 16'h0, 0);
    idle(3);
    chk("qc_impulse", 32'(m_tdata[31:16]), 32'd1000);
    strobe(14'($urandom), 16'h0, 0);
    idle(3);
    chk("qc_after", 32'(m_tdata[31:16]), 32'd0);

    qc_en = 1'b0;
    idle(1);
    qc_en = 1'b1; qc_delay = 0;
    strobe(0, 16'h0, 800);
    strobe(0, 16'h0, 0);
    idle(3);
    chk("qc_delay0", 32'(m_tdata[31:16]), 32'd200);

    qc_en = 1'b0;
    idle(1);
    qc_en = 1'b1; qc_delay = 15;
    for (int k = 0; k < 40; k++) begin
      strobe(14'($urandom), 16'(k), 16'(100 * (k + 1)));
      if (k % 7 == 3) idle(2);
    end
    qc_en = 1'b0;
    strobe(0, 16'h0, 555);
    qc_en = 1'b1; qc_delay = 3;
    for (int k = 0; k < 6; k++) strobe(0, 16'h0, 16'(400 * (k + 1)));
    idle(3);

    qc_en = 1'b0; ramp_step = 0; sv_tdata = 0;
    strobe(0, 16'h0, 0);
    ramp_step = 4096; sv_tdata = 16384;
    for (int k = 0; k < 3; k++) strobe(4000, 16'h0, 0);
    chk("ramp_busy_mid", 32'(ramp_busy), 32'd1);
    strobe(4000, 16'h0, 0);
    chk("ramp_busy_done", 32'(ramp_busy), 32'd0);
    strobe(4000, 16'h0, 0);
    idle(3);
    chk("ramp_full", 32'(m_tdata[31:16]), 32'd4000);
    ramp_step = 0; sv_tdata = 0;
    strobe(0, 16'h0, 0);
    ramp_step = 4096; sv_tdata = 16384;
    strobe(4000, 16'h0, 0);
    sv_tdata = 0;
    strobe(4000, 16'h0, 0);
    chk("retarget_busy", 32'(ramp_busy), 32'd0);
    idle(3);

    sv_tdata = 16384; ramp_step = 0;
    strobe(100, 16'h1111, 0);
    strobe(200, 16'h2222, 0);
    do_reset();
    idle(4);
    sv_tdata = 16384;
    strobe(300, 16'h3333, 0);
    strobe(300, 16'h3333, 0);
    idle(3);
    chk("post_reset", m_tdata, 32'h012C_3333);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) qc_en = ~qc_en;
      if ($urandom_range(0, 9) == 0) qc_delay = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) sv_tdata = 16'($urandom);
      if ($urandom_range(0, 15) == 0)
        case ($urandom_range(0, 2))
          0: ramp_step = 0;
          1: ramp_step = 16'($urandom_range(1, 2000));
          default: ramp_step = 16'($urandom);
        endcase
      qc_gain = 16'($urandom);
      x_in = 14'($urandom); lo_in = 16'($urandom); sig = 16'($urandom);
      sig_vld = 1'($urandom);
      s_tvalid = ($urandom_range(0, 3) != 0);
      sv_tvalid = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_tvalid = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
